i2s_stereo_transceiver: RTL and testbench
=========================================

# i2s_stereo_transceiver

Parametrised I2S master transceiver for the FIR engine audio path: generates mclk/sclk/lrck for an external codec (Pmod I2S2 class), deserialises stereo ADC samples, and serialises stereo DAC samples. It replaces the fixed 8-bit, fixed-ratio I2S logic with configurable sample width, slot length and clock ratio, and adds valid/ready sample handshakes, underrun/overrun flags and a run enable. It sits between the top-level `uio` pins and the filter datapath.

## Interface
- `DataWidth`, 8: sample bits per channel; legal range 1 to SlotBits-1.
- `SlotBitsLog2`, 5: log2 of sclk periods per channel slot; 32 slots means 64 fs.
- `MclkDivLog2`, 1: log2 of clk cycles per mclk period; must be at least 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run/stop for the interface.
- `mclk`, `sclk`, `lrck`  out  1 each  codec clocks; lrck low = left.
- `dac`  out  1  serial data to the codec.
- `adc`  in  1  serial data from the codec.
- `txLeft`, `txRight`  in  DataWidth each  playback pair.
- `txValid`  in  1; `txReady`  out  1: playback handshake.
- `rxLeft`, `rxRight`  out  DataWidth each  capture pair.
- `rxValid`  out  1; `rxReady`  in  1: capture handshake.
- `clearFlags`  in  1  synchronous clear of the sticky flags.
- `txUnderrun`, `rxOverrun`  out  1 each  sticky error flags.

## Operation
- Free-running counter `divCnt` of width W = MclkDivLog2+2+SlotBitsLog2+1.
  - `mclk` = divCnt[MclkDivLog2-1].
  - `sclk` = divCnt[MclkDivLog2+1]; sclk is always mclk/4.
  - `lrck` = divCnt[W-1].
  - Bit index b = divCnt[W-2:MclkDivLog2+2].
  - All clocks come straight from flops, with no glitches.
- Bit period b starts on the sclk falling transition (low bits wrap to 0).
- Standard I2S format:
  - Slot bit b=0 is the delay bit.
  - Bits b=1..DataWidth carry the sample, MSB first.
  - Remaining bits: `dac`=0 and `adc` is ignored.
- TX path:
  - One-entry hold register. `txReady` = hold empty.
  - A handshake (txValid && txReady) fills the hold.
  - Frame end (divCnt all-ones → 0): a full hold moves into the left/right shift registers and the hold empties.
  - Empty hold at frame end: load zeros and set `txUnderrun`.
- RX path:
  - `adc` is sampled on the clk edge where sclk goes 0→1, only for b in 1..DataWidth. No synchroniser; the codec launches data on the sclk falling edge.
  - At frame end, the left/right shift registers go to `rxLeft`/`rxRight` and `rxValid`=1.
  - `rxValid` clears on rxValid && rxReady.
  - Frame end while rxValid && !rxReady: overwrite the data, keep rxValid=1, set `rxOverrun`.
- Flags:
  - `clearFlags` clears both flags.
  - A set event in the same cycle wins over the clear.
- `enable`=0:
  - divCnt and all shift registers are held at 0, so mclk/sclk/lrck/dac = 0.
  - No frame-end events occur.
  - Hold register, rx outputs, rxValid and flags keep their values; both handshakes still operate.
  - A partial frame is discarded.
  - Re-enable starts at divCnt=0, i.e. the left slot, bit 0.
- Reset: every output is 0 except `txReady`=1; divCnt, hold and shift registers are 0.

## Timing
- Defaults give these periods: mclk 2 clk, sclk 8 clk, lrck 512 clk, left slot 256 clk.
- `dac` is a registered output. It changes on the same clk edge as sclk 1→0.
  - Left-channel MSB appears at frame offset 8 clk.
  - Right-channel MSB appears at offset 264 clk.
- Latency:
  - A pair accepted in frame N is transmitted in frame N+1.
  - The pair captured in frame N is presented at the edge ending frame N.
- `txReady` drops the cycle after acceptance and rises the cycle after the frame-end transfer.
- `rxValid` and the flags update on the frame-end edge.

## Structure
- Package `i2s_pkg`:
  - localparam `MclkPerSclkLog2`=2.
  - State enum for the hold register (`HOLD_EMPTY`, `HOLD_FULL`).
  - Function computing W from the parameters.
- Sub-module `i2s_clock_gen`:
  - Contains divCnt and the enable gating.
  - Outputs mclk/sclk/lrck, bit index, channel, and one-cycle strobes `sclkRise`, `sclkFall`, `frameEnd`.
- The transceiver top holds the hold register, shift registers, rx output registers and flags.

## Test plan
All cases use default parameters.
- Reset held, then released with enable=0 → all outputs 0, txReady=1, divCnt stays 0.
- enable=1 → mclk period 2, sclk period 8, lrck rises at clk 256 and falls at 512; sclk is 1 only during clk 4–7 of each bit.
- Loopback dac→adc:
  - Push txLeft=8'hA5, txRight=8'h3C in frame 0.
  - dac shows 1,0,1,0,0,1,0,1 at offsets 8..64 of frame 1.
  - At the end of frame 1: rxValid=1, rxLeft=8'hA5, rxRight=8'h3C.
- No txValid for a frame → dac=0 for the whole frame and txUnderrun=1 after frame end; clearFlags → 0.
- rxReady=0 across two frame ends with loopback of 8'h11 then 8'h22 → rxOverrun=1, rxLeft=8'h22, rxValid=1.
- enable dropped at offset 100:
  - Next edge: clocks=0, dac=0, no rxValid event.
  - Re-enable: lrck low and left MSB at offset 8 of the new frame.
  - Held tx pair is sent intact.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, constants and helpers for the I2S transceiver
package i2s_pkg;

    localparam int MclkPerSclkLog2 = 2;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Width of the free-running divider: mclk divide, mclk-per-sclk, slot bits, channel bit
    function automatic int cnt_width(input int slot_bits_log2, input int mclk_div_log2);
        return mclk_div_log2 + MclkPerSclkLog2 + slot_bits_log2 + 1;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - divider producing mclk/sclk/lrck, bit index and frame strobes
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int SlotBitsLog2 = 5,
    parameter int MclkDivLog2  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    mclk,
    output logic                    sclk,
    output logic                    lrck,
    output logic [SlotBitsLog2-1:0] bitIndex,
    output logic                    channel,
    output logic                    sclkRise,
    output logic                    sclkFall,
    output logic                    frameEnd
);

    localparam int W    = cnt_width(SlotBitsLog2, MclkDivLog2);
    localparam int LowW = MclkDivLog2 + MclkPerSclkLog2;

    logic [W-1:0]    divCnt;
    logic [LowW-1:0] low_bits;

    // Free-running divider; held at zero while stopped so a restart begins at left slot, bit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
        end else if (!enable) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + W'(1);
        end
    end

    assign low_bits = divCnt[LowW-1:0];

    // Codec clocks are plain divider bits, so they come straight from flops
    assign mclk     = divCnt[MclkDivLog2-1];
    assign sclk     = divCnt[LowW-1];
    assign lrck     = divCnt[W-1];
    assign channel  = divCnt[W-1];
    assign bitIndex = divCnt[W-2:LowW];

    // Strobes mark the clk edge at which the named transition happens
    assign sclkRise = enable && (low_bits == {1'b0, {(LowW-1){1'b1}}});
    assign sclkFall = enable && (&low_bits);
    assign frameEnd = enable && (&divCnt);

endmodule

// File: rtl/i2s_stereo_transceiver.sv
// rtl/i2s_stereo_transceiver.sv - I2S master with stereo capture/playback handshakes
module i2s_stereo_transceiver
    import i2s_pkg::*;
#(
    parameter int DataWidth    = 8,
    parameter int SlotBitsLog2 = 5,
    parameter int MclkDivLog2  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 mclk,
    output logic                 sclk,
    output logic                 lrck,
    output logic                 dac,
    input  logic                 adc,
    input  logic [DataWidth-1:0] txLeft,
    input  logic [DataWidth-1:0] txRight,
    input  logic                 txValid,
    output logic                 txReady,
    output logic [DataWidth-1:0] rxLeft,
    output logic [DataWidth-1:0] rxRight,
    output logic                 rxValid,
    input  logic                 rxReady,
    input  logic                 clearFlags,
    output logic                 txUnderrun,
    output logic                 rxOverrun
);

    localparam logic [SlotBitsLog2-1:0] LastDataIdx = SlotBitsLog2'(DataWidth);

    logic [SlotBitsLog2-1:0] bit_index;
    logic [SlotBitsLog2-1:0] next_index;
    logic                    channel;
    logic                    next_channel;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    frame_end;

    hold_state_t             hold_state;
    hold_state_t             hold_next;
    logic                    tx_accept;
    logic                    take_hold;
    logic                    underrun_evt;
    logic                    overrun_evt;
    logic                    rx_sample;
    logic                    tx_data_bit;

    logic [DataWidth-1:0]    hold_left;
    logic [DataWidth-1:0]    hold_right;
    logic [DataWidth-1:0]    tx_sh_left;
    logic [DataWidth-1:0]    tx_sh_right;
    logic [DataWidth-1:0]    rx_sh_left;
    logic [DataWidth-1:0]    rx_sh_right;

    i2s_clock_gen #(
        .SlotBitsLog2 (SlotBitsLog2),
        .MclkDivLog2  (MclkDivLog2)
    ) u_clock_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mclk     (mclk),
        .sclk     (sclk),
        .lrck     (lrck),
        .bitIndex (bit_index),
        .channel  (channel),
        .sclkRise (sclk_rise),
        .sclkFall (sclk_fall),
        .frameEnd (frame_end)
    );

    // dac is launched one edge early, so it is driven from the bit period about to start
    assign next_index   = bit_index + SlotBitsLog2'(1);
    assign next_channel = channel ^ (&bit_index);
    assign tx_data_bit  = (next_index != '0) && (next_index <= LastDataIdx);
    assign rx_sample    = sclk_rise && (bit_index != '0) && (bit_index <= LastDataIdx);

    assign txReady     = (hold_state == HOLD_EMPTY);
    assign tx_accept   = txValid && txReady;
    assign overrun_evt = frame_end && rxValid && !rxReady;

    // Hold register occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_state <= HOLD_EMPTY;
        end else begin
            hold_state <= hold_next;
        end
    end

    // Hold fill/drain decisions; an empty hold at frame end is an underrun
    always_comb begin
        hold_next    = hold_state;
        take_hold    = 1'b0;
        underrun_evt = 1'b0;
        case (hold_state)
            HOLD_EMPTY: begin
                if (frame_end) begin
                    underrun_evt = 1'b1;
                end
                if (txValid) begin
                    hold_next = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (frame_end) begin
                    take_hold = 1'b1;
                    hold_next = HOLD_EMPTY;
                end
            end
            default: hold_next = HOLD_EMPTY;
        endcase
    end

    // Playback pair captured on handshake; kept across stop/start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_left  <= '0;
            hold_right <= '0;
        end else if (tx_accept) begin
            hold_left  <= txLeft;
            hold_right <= txRight;
        end
    end

    // Serial shifters and dac; stopping wipes any partially transferred frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sh_left  <= '0;
            tx_sh_right <= '0;
            rx_sh_left  <= '0;
            rx_sh_right <= '0;
            dac         <= 1'b0;
        end else if (!enable) begin
            tx_sh_left  <= '0;
            tx_sh_right <= '0;
            rx_sh_left  <= '0;
            rx_sh_right <= '0;
            dac         <= 1'b0;
        end else begin
            if (frame_end) begin
                tx_sh_left  <= take_hold ? hold_left  : '0;
                tx_sh_right <= take_hold ? hold_right : '0;
                rx_sh_left  <= '0;
                rx_sh_right <= '0;
            end else if (rx_sample) begin
                if (channel) begin
                    rx_sh_right <= (rx_sh_right << 1) | DataWidth'(adc);
                end else begin
                    rx_sh_left  <= (rx_sh_left << 1) | DataWidth'(adc);
                end
            end
            if (sclk_fall) begin
                if (!tx_data_bit) begin
                    dac <= 1'b0;
                end else if (next_channel) begin
                    dac         <= tx_sh_right[DataWidth-1];
                    tx_sh_right <= tx_sh_right << 1;
                end else begin
                    dac        <= tx_sh_left[DataWidth-1];
                    tx_sh_left <= tx_sh_left << 1;
                end
            end
        end
    end

    // Captured pair presented at frame end; unread data is overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxLeft  <= '0;
            rxRight <= '0;
            rxValid <= 1'b0;
        end else if (frame_end) begin
            rxLeft  <= rx_sh_left;
            rxRight <= rx_sh_right;
            rxValid <= 1'b1;
        end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txUnderrun <= 1'b0;
            rxOverrun  <= 1'b0;
        end else begin
            if (underrun_evt) begin
                txUnderrun <= 1'b1;
            end else if (clearFlags) begin
                txUnderrun <= 1'b0;
            end
            if (overrun_evt) begin
                rxOverrun <= 1'b1;
            end else if (clearFlags) begin
                rxOverrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_transceiver.sv
// tb/tb_i2s_stereo_transceiver.sv - directed bench for the I2S stereo transceiver
module tb_i2s_stereo_transceiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       mclk, sclk, lrck, dac, adc;
    logic [7:0] txLeft = 8'h00, txRight = 8'h00;
    logic       txValid = 1'b0, txReady;
    logic [7:0] rxLeft, rxRight;
    logic       rxValid, rxReady = 1'b0;
    logic       clearFlags = 1'b0;
    logic       txUnderrun, rxOverrun;

    int vectors = 0;
    int miscompares = 0;
    int off = 0;

    i2s_stereo_transceiver #(
        .DataWidth    (8),
        .SlotBitsLog2 (5),
        .MclkDivLog2  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mclk       (mclk),
        .sclk       (sclk),
        .lrck       (lrck),
        .dac        (dac),
        .adc        (adc),
        .txLeft     (txLeft),
        .txRight    (txRight),
        .txValid    (txValid),
        .txReady    (txReady),
        .rxLeft     (rxLeft),
        .rxRight    (rxRight),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .clearFlags (clearFlags),
        .txUnderrun (txUnderrun),
        .rxOverrun  (rxOverrun)
    );

    always #5 clk = ~clk;

    assign adc = dac;

    task automatic step();
        @(negedge clk);
        off = off + 1;
    endtask

    task automatic run_to(input int target);
        while (off < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; txValid = 1'b0; txLeft = 8'h00; txRight = 8'h00;
        rxReady = 1'b0; clearFlags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        off = 0;
    endtask

    task automatic push(input logic [7:0] l, input logic [7:0] r);
        txLeft = l; txRight = r; txValid = 1'b1;
        step();
        txValid = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        vectors++; if ({mclk, sclk, lrck, dac, rxValid, txUnderrun, rxOverrun} !== 7'b0) begin
            miscompares++; $display("FAIL rst_outputs got %b want 0000000", {mclk, sclk, lrck, dac, rxValid, txUnderrun, rxOverrun}); end
        vectors++; if ({rxLeft, rxRight} !== 16'h0000) begin
            miscompares++; $display("FAIL rst_rx_data got %h want 0000", {rxLeft, rxRight}); end
        vectors++; if (txReady !== 1'b1) begin
            miscompares++; $display("FAIL rst_tx_ready got %b want 1", txReady); end
        reset = 1'b0; off = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if ({mclk, sclk, lrck, dac} !== 4'b0 || txReady !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin
            miscompares++; $display("FAIL rst_idle_clocks bad_cycles %0d want 0", bad); end
    endtask

    task automatic test_clocks();
        int bad_m, bad_s, bad_l, m;
        bad_m = 0; bad_s = 0; bad_l = 0;
        do_reset();
        enable = 1'b1; rxReady = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            m = off % 512;
            if (mclk !== logic'((off % 2) == 1)) bad_m++;
            if (sclk !== logic'((off % 8) >= 4)) bad_s++;
            if (lrck !== logic'(m >= 256)) bad_l++;
        end
        vectors++; if (bad_m !== 0) begin miscompares++; $display("FAIL clk_mclk bad_cycles %0d want 0", bad_m); end
        vectors++; if (bad_s !== 0) begin miscompares++; $display("FAIL clk_sclk bad_cycles %0d want 0", bad_s); end
        vectors++; if (bad_l !== 0) begin miscompares++; $display("FAIL clk_lrck bad_cycles %0d want 0", bad_l); end
        run_to(812);
        vectors++; if ({mclk, sclk, lrck} !== 3'b011) begin
            miscompares++; $display("FAIL clk_pre_async got %b want 011", {mclk, sclk, lrck}); end
        reset = 1'b1;
        #1;
        vectors++; if ({mclk, sclk, lrck, txReady} !== 4'b0001) begin
            miscompares++; $display("FAIL clk_async_reset got %b want 0001", {mclk, sclk, lrck, txReady}); end
    endtask

    task automatic test_loopback();
        logic [7:0] want_l, want_r;
        want_l = 8'hA5; want_r = 8'h3C;
        do_reset();
        enable = 1'b1; rxReady = 1'b1;
        run_to(10);
        push(8'hA5, 8'h3C);
        vectors++; if (txReady !== 1'b0) begin miscompares++; $display("FAIL lb_ready_drop got %b want 0", txReady); end
        run_to(512);
        vectors++; if ({txReady, rxValid, rxLeft} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL lb_frame0_end got %b/%b/%h want 1/1/00", txReady, rxValid, rxLeft); end
        run_to(519);
        vectors++; if (dac !== 1'b0) begin miscompares++; $display("FAIL lb_delay_bit got %b want 0", dac); end
        for (int i = 0; i < 8; i++) begin
            run_to(520 + 8 * i);
            vectors++; if (dac !== want_l[7-i]) begin
                miscompares++; $display("FAIL lb_left_bit%0d got %b want %b", i, dac, want_l[7-i]); end
        end
        run_to(584);
        vectors++; if (dac !== 1'b0) begin miscompares++; $display("FAIL lb_left_pad got %b want 0", dac); end
        for (int i = 0; i < 8; i++) begin
            run_to(776 + 8 * i);
            vectors++; if (dac !== want_r[7-i]) begin
                miscompares++; $display("FAIL lb_right_bit%0d got %b want %b", i, dac, want_r[7-i]); end
        end
        run_to(1024);
        vectors++; if (rxValid !== 1'b1) begin miscompares++; $display("FAIL lb_rx_valid got %b want 1", rxValid); end
        vectors++; if (rxLeft !== 8'hA5) begin miscompares++; $display("FAIL lb_rx_left got %h want a5", rxLeft); end
        vectors++; if (rxRight !== 8'h3C) begin miscompares++; $display("FAIL lb_rx_right got %h want 3c", rxRight); end
        vectors++; if (txUnderrun !== 1'b1) begin miscompares++; $display("FAIL lb_underrun got %b want 1", txUnderrun); end
    endtask

    task automatic test_underrun();
        int bad;
        bad = 0;
        while (off < 1535) begin
            step();
            if (dac !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ur_dac_zero bad_cycles %0d want 0", bad); end
        vectors++; if (txUnderrun !== 1'b1) begin miscompares++; $display("FAIL ur_sticky got %b want 1", txUnderrun); end
        clearFlags = 1'b1;
        step();
        vectors++; if (txUnderrun !== 1'b1) begin miscompares++; $display("FAIL ur_set_wins got %b want 1", txUnderrun); end
        vectors++; if (rxLeft !== 8'h00) begin miscompares++; $display("FAIL ur_rx_zero got %h want 00", rxLeft); end
        step();
        clearFlags = 1'b0;
        vectors++; if (txUnderrun !== 1'b0) begin miscompares++; $display("FAIL ur_cleared got %b want 0", txUnderrun); end
        step();
        vectors++; if (txUnderrun !== 1'b0) begin miscompares++; $display("FAIL ur_stay_clear got %b want 0", txUnderrun); end
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1; rxReady = 1'b1;
        run_to(10);
        push(8'h11, 8'h99);
        run_to(513);
        rxReady = 1'b0;
        vectors++; if (rxValid !== 1'b0) begin miscompares++; $display("FAIL ov_drained got %b want 0", rxValid); end
        run_to(520);
        push(8'h22, 8'h44);
        run_to(1024);
        vectors++; if ({rxValid, rxOverrun, rxLeft, rxRight} !== {1'b1, 1'b0, 8'h11, 8'h99}) begin
            miscompares++; $display("FAIL ov_first got %b/%b/%h/%h want 1/0/11/99", rxValid, rxOverrun, rxLeft, rxRight); end
        run_to(1536);
        vectors++; if (rxOverrun !== 1'b1) begin miscompares++; $display("FAIL ov_flag got %b want 1", rxOverrun); end
        vectors++; if ({rxValid, rxLeft, rxRight} !== {1'b1, 8'h22, 8'h44}) begin
            miscompares++; $display("FAIL ov_overwrite got %b/%h/%h want 1/22/44", rxValid, rxLeft, rxRight); end
        rxReady = 1'b1;
        step();
        vectors++; if ({rxValid, rxOverrun} !== 2'b01) begin
            miscompares++; $display("FAIL ov_consume got %b want 01", {rxValid, rxOverrun}); end
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        vectors++; if (rxOverrun !== 1'b0) begin miscompares++; $display("FAIL ov_clear got %b want 0", rxOverrun); end
    endtask

    task automatic test_disable();
        int bad;
        logic [7:0] want_l, want_r;
        bad = 0; want_l = 8'h96; want_r = 8'h81;
        do_reset();
        enable = 1'b1; rxReady = 1'b1;
        run_to(10);
        push(8'hC3, 8'h5A);
        run_to(612);
        vectors++; if ({sclk, txReady} !== 2'b11) begin
            miscompares++; $display("FAIL dis_pre got %b want 11", {sclk, txReady}); end
        enable = 1'b0;
        step();
        vectors++; if ({mclk, sclk, lrck, dac} !== 4'b0) begin
            miscompares++; $display("FAIL dis_stopped got %b want 0000", {mclk, sclk, lrck, dac}); end
        push(8'h96, 8'h81);
        vectors++; if (txReady !== 1'b0) begin miscompares++; $display("FAIL dis_handshake got %b want 0", txReady); end
        for (int i = 0; i < 600; i++) begin
            step();
            if ({mclk, sclk, lrck, dac, rxValid} !== 5'b0 || txReady !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL dis_idle bad_cycles %0d want 0", bad); end
        enable = 1'b1; off = 0;
        run_to(8);
        vectors++; if ({lrck, dac} !== 2'b00) begin
            miscompares++; $display("FAIL dis_restart got %b want 00", {lrck, dac}); end
        run_to(512);
        vectors++; if ({txUnderrun, txReady, rxValid, rxLeft} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL dis_frameA got %b/%b/%b/%h want 0/1/1/00", txUnderrun, txReady, rxValid, rxLeft); end
        run_to(519);
        vectors++; if (dac !== 1'b0) begin miscompares++; $display("FAIL dis_delay_bit got %b want 0", dac); end
        for (int i = 0; i < 8; i++) begin
            run_to(520 + 8 * i);
            vectors++; if (dac !== want_l[7-i]) begin
                miscompares++; $display("FAIL dis_left_bit%0d got %b want %b", i, dac, want_l[7-i]); end
        end
        for (int i = 0; i < 8; i++) begin
            run_to(776 + 8 * i);
            vectors++; if (dac !== want_r[7-i]) begin
                miscompares++; $display("FAIL dis_right_bit%0d got %b want %b", i, dac, want_r[7-i]); end
        end
        run_to(1024);
        vectors++; if ({rxValid, rxLeft, rxRight} !== {1'b1, 8'h96, 8'h81}) begin
            miscompares++; $display("FAIL dis_rx_pair got %b/%h/%h want 1/96/81", rxValid, rxLeft, rxRight); end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_loopback();
        test_underrun();
        test_overrun();
        test_disable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
